divider_sched: RTL and testbench

DIVIDER_SCHED -- requirements
Module: divider_sched

---
 rtl/divider_sched_pkg.sv | 15 +
 rtl/divider_sched_arb.sv | 38 +++
 rtl/divider_sched.sv | 159 +++++++++++++++
 tb/tb_divider_sched.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_sched_pkg.sv
// Shared types and defaults for the two-requester divider scheduler.
package divider_sched_pkg;

  localparam int C_NUM_BITS_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    RESP
  } state_e;

  typedef logic req_id_t;

endpackage

// File: rtl/divider_sched_arb.sv
// Two-way round-robin arbiter; the pointer remembers who was served last.
module rr_arbiter_2
  import divider_sched_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       accept_i,
  output logic [1:0] grant_o
);

  req_id_t last_q;
  req_id_t last_d;

  // When both requesters are pending, the one not served last wins.
  always_comb begin
    grant_o = 2'b00;
    if (req_i[0] && (!req_i[1] || last_q)) begin
      grant_o[0] = 1'b1;
    end else if (req_i[1]) begin
      grant_o[1] = 1'b1;
    end
    last_d = last_q;
    if (accept_i) begin
      last_d = grant_o[1];
    end
  end

  // Reset to 1 so that requester 0 wins the first contest.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/divider_sched.sv
// Schedules two requesters onto one shared iterative divider datapath.
// Optional divide-by-zero shortcut: define DIVIDER_SCHED_DIV_ZERO_EN (adds RSP_DZ).
module divider_sched
  import divider_sched_pkg::*;
#(
  parameter int C_NUM_BITS = C_NUM_BITS_DEFAULT
) (
  input  logic                  CK,
  input  logic                  R,
  input  logic                  REQ0_VALID,
  input  logic                  REQ1_VALID,
  output logic                  REQ0_READY,
  output logic                  REQ1_READY,
  input  logic [C_NUM_BITS-1:0] REQ0_A,
  input  logic [C_NUM_BITS-1:0] REQ0_B,
  input  logic [C_NUM_BITS-1:0] REQ1_A,
  input  logic [C_NUM_BITS-1:0] REQ1_B,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic                  RSP_ID,
  output logic [C_NUM_BITS-1:0] RSP_Q,
  output logic [C_NUM_BITS-1:0] RSP_REM,
`ifdef DIVIDER_SCHED_DIV_ZERO_EN
  output logic                  RSP_DZ,
`endif
  output logic                  DP_E,
  output logic                  DP_LOAD,
  output logic [C_NUM_BITS-1:0] DP_A,
  output logic [C_NUM_BITS-1:0] DP_B,
  input  logic [C_NUM_BITS-1:0] DP_Q,
  input  logic [C_NUM_BITS-1:0] DP_REM
);

  localparam int CNT_W = $clog2(C_NUM_BITS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_NUM_BITS);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [C_NUM_BITS-1:0] a_q, b_q;
  logic [C_NUM_BITS-1:0] q_q, q_d;
  logic [C_NUM_BITS-1:0] rem_q, rem_d;
  logic [C_NUM_BITS-1:0] sel_a, sel_b;
  req_id_t               id_q;
  logic [1:0]            grant;
  logic                  in_idle;
  logic                  accept;
  logic                  cap_res;
`ifdef DIVIDER_SCHED_DIV_ZERO_EN
  logic                  dz_q, dz_d;
`endif

  rr_arbiter_2 u_arb (
    .clk_i   (CK),
    .rst_i   (R),
    .req_i   ({REQ1_VALID, REQ0_VALID}),
    .accept_i(accept),
    .grant_o (grant)
  );

  // Handshake is only offered while idle and not being reset.
  assign in_idle    = (state_q == IDLE) && !R;
  assign REQ0_READY = in_idle && grant[0];
  assign REQ1_READY = in_idle && grant[1];
  assign accept     = REQ0_READY || REQ1_READY;
  assign sel_a      = grant[1] ? REQ1_A : REQ0_A;
  assign sel_b      = grant[1] ? REQ1_B : REQ0_B;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cap_res   = 1'b0;
    q_d       = DP_Q;
    rem_d     = DP_REM;
    DP_E      = 1'b0;
    DP_LOAD   = 1'b0;
    RSP_VALID = 1'b0;
`ifdef DIVIDER_SCHED_DIV_ZERO_EN
    dz_d      = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = LOAD;
`ifdef DIVIDER_SCHED_DIV_ZERO_EN
          // Zero divisor never touches the datapath; answer immediately.
          if (sel_b == '0) begin
            state_d = RESP;
            cap_res = 1'b1;
            q_d     = '1;
            rem_d   = sel_a;
            dz_d    = 1'b1;
          end
`endif
        end
      end
      LOAD: begin
        DP_E    = 1'b1;
        DP_LOAD = 1'b1;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        DP_E  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_d == CNT_LAST) begin
          state_d = RESP;
          cap_res = 1'b1;
        end
      end
      RESP: begin
        RSP_VALID = 1'b1;
        if (RSP_READY) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CK) begin
    if (R) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      id_q    <= 1'b0;
      q_q     <= '0;
      rem_q   <= '0;
`ifdef DIVIDER_SCHED_DIV_ZERO_EN
      dz_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        a_q  <= sel_a;
        b_q  <= sel_b;
        id_q <= grant[1];
      end
      if (cap_res) begin
        q_q   <= q_d;
        rem_q <= rem_d;
`ifdef DIVIDER_SCHED_DIV_ZERO_EN
        dz_q  <= dz_d;
`endif
      end
    end
  end

  assign DP_A    = a_q;
  assign DP_B    = b_q;
  assign RSP_ID  = id_q;
  assign RSP_Q   = q_q;
  assign RSP_REM = rem_q;
`ifdef DIVIDER_SCHED_DIV_ZERO_EN
  assign RSP_DZ  = dz_q;
`endif

endmodule

// File: tb/tb_divider_sched.sv
// Randomised scoreboard bench for divider_sched with a behavioural datapath and cycle-offset model.
// Honours DIVIDER_SCHED_DIV_ZERO_EN to exercise the RSP_DZ shortcut.
module tb_divider_sched;

  localparam int N = 4;
`ifdef DIVIDER_SCHED_DIV_ZERO_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  logic         CK = 1'b0;
  logic         R = 1'b1;
  logic         REQ0_VALID = 1'b0, REQ1_VALID = 1'b0;
  logic         REQ0_READY, REQ1_READY;
  logic [N-1:0] REQ0_A = '0, REQ0_B = '0, REQ1_A = '0, REQ1_B = '0;
  logic         RSP_VALID, RSP_ID;
  logic         RSP_READY = 1'b1;
  logic [N-1:0] RSP_Q, RSP_REM;
  logic         DP_E, DP_LOAD;
  logic [N-1:0] DP_A, DP_B, DP_Q, DP_REM;
`ifdef DIVIDER_SCHED_DIV_ZERO_EN
  logic         RSP_DZ;
`endif

  always #5 CK = ~CK;

  divider_sched #(.C_NUM_BITS(N)) dut (
    .CK(CK), .R(R),
    .REQ0_VALID(REQ0_VALID), .REQ1_VALID(REQ1_VALID),
    .REQ0_READY(REQ0_READY), .REQ1_READY(REQ1_READY),
    .REQ0_A(REQ0_A), .REQ0_B(REQ0_B), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID),
    .RSP_Q(RSP_Q), .RSP_REM(RSP_REM),
`ifdef DIVIDER_SCHED_DIV_ZERO_EN
    .RSP_DZ(RSP_DZ),
`endif
    .DP_E(DP_E), .DP_LOAD(DP_LOAD), .DP_A(DP_A), .DP_B(DP_B),
    .DP_Q(DP_Q), .DP_REM(DP_REM)
  );

  function automatic logic [N-1:0] refQ(input logic [N-1:0] a, input logic [N-1:0] b);
    if (b == '0) return '1;
    return a / b;
  endfunction

  function automatic logic [N-1:0] refRem(input logic [N-1:0] a, input logic [N-1:0] b);
    if (b == '0) return a;
    return a % b;
  endfunction

  // Behavioural datapath: result shows once N enabled steps (including the current one) follow a load.
  logic [N-1:0] dpA = '0, dpB = '0;
  int           dpSteps = 0;
  int           dpEff;
  always @(posedge CK) begin
    if (DP_E) begin
      if (DP_LOAD) begin
        dpA     <= DP_A;
        dpB     <= DP_B;
        dpSteps <= 0;
      end else begin
        dpSteps <= dpSteps + 1;
      end
    end
  end
  assign dpEff  = dpSteps + ((DP_E && !DP_LOAD) ? 1 : 0);
  assign DP_Q   = (dpEff >= N) ? refQ(dpA, dpB) : '0;
  assign DP_REM = (dpEff >= N) ? refRem(dpA, dpB) : '0;

  typedef struct { logic [N-1:0] a; logic [N-1:0] b; } op_t;
  typedef struct { logic id; logic [N-1:0] q; logic [N-1:0] rem; logic dz; } exp_t;

  op_t  pend0[$], pend1[$];
  exp_t sb[$];
  int   idLog[$];
  int   nChecks = 0, nFail = 0;
  bit   accFlag0 = 0, accFlag1 = 0;
  bit   rstReq = 1;
  int   rspMode = 0;
  bit   busy = 0, curDz = 0, rstSeen = 0, lastSrv = 1;
  int   offset = 0;
  logic [N-1:0] opA = '0, opB = '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic failNow(input string name);
    nChecks++;
    nFail++;
    $display("[TB] FAIL %s: bound expired at %0t", name, $time);
  endtask

  task automatic applyStimulus();
    @(negedge CK);
    if (accFlag0 && pend0.size() > 0) void'(pend0.pop_front());
    if (accFlag1 && pend1.size() > 0) void'(pend1.pop_front());
    R = rstReq;
    REQ0_VALID = !rstReq && (pend0.size() > 0);
    REQ1_VALID = !rstReq && (pend1.size() > 0);
    if (pend0.size() > 0) begin REQ0_A = pend0[0].a; REQ0_B = pend0[0].b; end
    if (pend1.size() > 0) begin REQ1_A = pend1[0].a; REQ1_B = pend1[0].b; end
    case (rspMode)
      0:       RSP_READY = 1'b1;
      1:       RSP_READY = 1'($urandom_range(0, 1));
      default: RSP_READY = 1'b0;
    endcase
  endtask

  task automatic waitIdle(input int budget);
    int k = 0;
    while (pend0.size() > 0 || pend1.size() > 0 || busy || sb.size() > 0) begin
      if (k >= budget) begin
        failNow("drain_timeout");
        return;
      end
      applyStimulus();
      k++;
    end
  endtask

  task automatic push0(input int a, input int b);
    op_t o;
    o.a = N'(a); o.b = N'(b);
    pend0.push_back(o);
  endtask

  task automatic push1(input int a, input int b);
    op_t o;
    o.a = N'(a); o.b = N'(b);
    pend1.push_back(o);
  endtask

  // Cycle model: phase of the current operation is its offset in cycles from the accept.
  always @(negedge CK) begin
    bit   g0, g1, doneNow;
    exp_t e;
    #2;
    accFlag0 = 0;
    accFlag1 = 0;
    if (rstSeen) begin
      checkOutput("rst_rsp_id", RSP_ID, 0);
      checkOutput("rst_rsp_q", RSP_Q, 0);
      checkOutput("rst_rsp_rem", RSP_REM, 0);
`ifdef DIVIDER_SCHED_DIV_ZERO_EN
      checkOutput("rst_rsp_dz", RSP_DZ, 0);
`endif
    end
    if (R) begin
      checkOutput("ready0_in_reset", REQ0_READY, 0);
      checkOutput("ready1_in_reset", REQ1_READY, 0);
      busy = 0; lastSrv = 1; opA = '0; opB = '0;
      sb.delete();
      rstSeen = 1;
    end else begin
      rstSeen = 0;
      doneNow = 0;
      if (busy) begin
        offset++;
        checkOutput("ready0_busy", REQ0_READY, 0);
        checkOutput("ready1_busy", REQ1_READY, 0);
        checkOutput("dp_a_hold", DP_A, opA);
        checkOutput("dp_b_hold", DP_B, opB);
        if (offset < (curDz ? 1 : N + 2)) begin
          checkOutput("rsp_valid_early", RSP_VALID, 0);
          checkOutput("dp_load", DP_LOAD, (offset == 1));
          checkOutput("dp_e_run", DP_E, (offset <= N + 1));
        end else begin
          checkOutput("rsp_valid", RSP_VALID, 1);
          checkOutput("dp_e_resp", DP_E, 0);
          checkOutput("dp_load_resp", DP_LOAD, 0);
          if (RSP_READY) doneNow = 1;
        end
      end else begin
        g0 = REQ0_VALID && (!REQ1_VALID || lastSrv == 1);
        g1 = REQ1_VALID && (!REQ0_VALID || lastSrv == 0);
        checkOutput("ready0_idle", REQ0_READY, g0);
        checkOutput("ready1_idle", REQ1_READY, g1);
        checkOutput("rsp_valid_idle", RSP_VALID, 0);
        checkOutput("dp_e_idle", DP_E, 0);
        checkOutput("dp_load_idle", DP_LOAD, 0);
        checkOutput("dp_a_idle", DP_A, opA);
        checkOutput("dp_b_idle", DP_B, opB);
        if (g0 || g1) begin
          opA = g1 ? REQ1_A : REQ0_A;
          opB = g1 ? REQ1_B : REQ0_B;
          curDz = DZ_EN && (opB == '0);
          e.id = g1; e.q = refQ(opA, opB); e.rem = refRem(opA, opB); e.dz = curDz;
          sb.push_back(e);
          lastSrv = g1;
          busy = 1;
          offset = 0;
          accFlag0 = !g1;
          accFlag1 = g1;
        end
      end
      if (doneNow) busy = 0;
    end
  end

  // Monitor: pops the scoreboard on every response handshake, checks stability while stalled.
  bit           prevStall = 0;
  logic [N-1:0] prevQ, prevRem;
  logic         prevId;
  always @(negedge CK) begin
    exp_t e;
    #3;
    if (R) begin
      prevStall = 0;
    end else if (RSP_VALID) begin
      if (prevStall) begin
        checkOutput("stall_q", RSP_Q, prevQ);
        checkOutput("stall_rem", RSP_REM, prevRem);
        checkOutput("stall_id", RSP_ID, prevId);
      end
      if (RSP_READY) begin
        if (sb.size() == 0) begin
          failNow("rsp_unexpected");
        end else begin
          e = sb.pop_front();
          checkOutput("rsp_id", RSP_ID, e.id);
          checkOutput("rsp_q", RSP_Q, e.q);
          checkOutput("rsp_rem", RSP_REM, e.rem);
`ifdef DIVIDER_SCHED_DIV_ZERO_EN
          checkOutput("rsp_dz", RSP_DZ, e.dz);
`endif
          idLog.push_back(int'(RSP_ID));
        end
      end
      prevStall = !RSP_READY;
      prevQ = RSP_Q; prevRem = RSP_REM; prevId = RSP_ID;
    end else begin
      prevStall = 0;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int k;
    rstReq = 1;
    repeat (2) applyStimulus();
    rstReq = 0;

    $display("[TB] single divide 13/3");
    push0(13, 3);
    waitIdle(40);

    $display("[TB] arbitration order after reset");
    rstReq = 1;
    repeat (2) applyStimulus();
    rstReq = 0;
    idLog.delete();
    push0(6, 2); push0(11, 4);
    push1(9, 3); push1(14, 5);
    waitIdle(80);
    checkOutput("order_count", idLog.size(), 4);
    for (int i = 0; i < idLog.size() && i < 4; i++) checkOutput("order_id", idLog[i], i % 2);

    $display("[TB] response stall");
    rspMode = 2;
    push0(12, 5);
    k = 0;
    while (!RSP_VALID && k < 20) begin applyStimulus(); k++; end
    if (!RSP_VALID) failNow("stall_wait");
    push1(8, 3);
    repeat (5) applyStimulus();
    rspMode = 0;
    waitIdle(40);

    $display("[TB] reset in the middle of RUN");
    push0(7, 2);
    k = 0;
    while (!(busy && offset == 2) && k < 20) begin applyStimulus(); k++; end
    if (!(busy && offset == 2)) failNow("run_wait");
    rstReq = 1;
    R = 1'b1;
    applyStimulus();
    rstReq = 0;
    repeat (3) applyStimulus();
    push0(10, 3);
    waitIdle(40);

    $display("[TB] boundary operands");
    push0(15, 1);
    push0(2, 7);
    waitIdle(60);
    push1(9, 0);
    waitIdle(40);

    $display("[TB] random traffic");
    rspMode = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 5) == 0) push0(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      if ($urandom_range(0, 5) == 0) push1(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      applyStimulus();
    end
    waitIdle(2000);
    rspMode = 0;
    repeat (3) applyStimulus();
    checkOutput("scoreboard_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
